aes_kat_checker: RTL and testbench

AES_KAT_CHECKER -- requirements
Module: aes_kat_checker

---
 rtl/aes_kat_checker.sv | 127 ++++++++++++
 tb/tb_aes_kat_checker.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_kat_checker.sv
// Scoreboard for a 128-bit block core: queues expected blocks and compares them
// against the core's output stream one cycle after each result arrives.
module aes_kat_checker #(
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 16,
  parameter int HALT_ON_ERR = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clear,
  input  logic [127:0]       i_exp_data,
  input  logic               i_exp_valid,
  output logic               o_exp_ready,
  input  logic [127:0]       i_data,
  input  logic               i_data_valid,
  output logic [CNT_W-1:0]   o_pass_cnt,
  output logic [CNT_W-1:0]   o_fail_cnt,
  output logic               o_error,
  output logic               o_unexp,
  output logic [CNT_W-1:0]   o_fail_idx,
  output logic [127:0]       o_fail_data,
  output logic [127:0]       o_fail_exp,
  output logic               o_idle
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, HALT} state_e;

  state_e             state_q, state_d;
  logic [127:0]       mem_q [DEPTH];
  logic [AW-1:0]      wptr_q, rptr_q;
  logic [AW:0]        cnt_q, cnt_d;
  logic               cmp_vld_q;
  logic [127:0]       cmp_data_q, cmp_exp_q;
  logic [CNT_W-1:0]   pass_q, fail_q, idx_q, fidx_q;
  logic [127:0]       fdata_q, fexp_q;
  logic               err_q, unexp_q;

  logic empty, full, halted, push, pop, unexp_ev, cmp_ev, mism, clr;

  assign clr      = reset | i_clear;
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign halted   = (state_q == HALT);
  assign push     = i_exp_valid & o_exp_ready;
  // A result arriving on an empty queue is never matched against a same-cycle push.
  assign pop      = i_data_valid & ~empty & ~halted;
  assign unexp_ev = i_data_valid & empty & ~halted;
  assign cmp_ev   = cmp_vld_q & ~halted;
  assign mism     = cmp_ev & (cmp_data_q != cmp_exp_q);

  always_comb begin
    cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    state_d = state_q;
    if (halted)
      state_d = HALT;
    else if (mism && (HALT_ON_ERR != 0))
      state_d = HALT;
    else
      state_d = (cnt_d == '0) ? IDLE : WAIT;
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wptr_q] <= i_exp_data;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      cmp_vld_q  <= 1'b0;
      cmp_data_q <= '0;
      cmp_exp_q  <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      idx_q      <= '0;
      fidx_q     <= '0;
      fdata_q    <= '0;
      fexp_q     <= '0;
      err_q      <= 1'b0;
      unexp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmp_vld_q <= pop;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop) begin
        rptr_q     <= rptr_q + 1'b1;
        cmp_data_q <= i_data;
        cmp_exp_q  <= mem_q[rptr_q];
      end
      if (cmp_ev) begin
        idx_q <= idx_q + 1'b1;
        if (!mism) begin
          if (pass_q != '1) pass_q <= pass_q + 1'b1;
        end else begin
          if (fail_q != '1) fail_q <= fail_q + 1'b1;
          err_q <= 1'b1;
          // fail_q saturates rather than wraps, so zero means no earlier mismatch
          if (fail_q == '0) begin
            fidx_q  <= idx_q;
            fdata_q <= cmp_data_q;
            fexp_q  <= cmp_exp_q;
          end
        end
      end
      if (unexp_ev) begin
        unexp_q <= 1'b1;
        err_q   <= 1'b1;
      end
    end
  end

  assign o_exp_ready = ~full & ~halted;
  assign o_pass_cnt  = pass_q;
  assign o_fail_cnt  = fail_q;
  assign o_error     = err_q;
  assign o_unexp     = unexp_q;
  assign o_fail_idx  = fidx_q;
  assign o_fail_data = fdata_q;
  assign o_fail_exp  = fexp_q;
  assign o_idle      = (state_q == IDLE) & ~cmp_vld_q;

endmodule

// File: tb/tb_aes_kat_checker.sv
// Randomized and directed bench for aes_kat_checker against a queue-based model.
module tb_aes_kat_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] KAT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // main instance: defaults
  logic         m_rst, m_clr, m_ev, m_dv, m_rdy, m_err, m_unexp, m_idle;
  logic [127:0] m_ed, m_d, m_fdata, m_fexp;
  logic [15:0]  m_pass, m_fail, m_fidx;

  aes_kat_checker u_main (
    .clk(clk), .reset(m_rst), .i_clear(m_clr),
    .i_exp_data(m_ed), .i_exp_valid(m_ev), .o_exp_ready(m_rdy),
    .i_data(m_d), .i_data_valid(m_dv),
    .o_pass_cnt(m_pass), .o_fail_cnt(m_fail), .o_error(m_err), .o_unexp(m_unexp),
    .o_fail_idx(m_fidx), .o_fail_data(m_fdata), .o_fail_exp(m_fexp), .o_idle(m_idle)
  );

  // halt-on-error instance
  logic         h_rst, h_clr, h_ev, h_dv, h_rdy, h_err, h_unexp, h_idle;
  logic [127:0] h_ed, h_d, h_fdata, h_fexp;
  logic [15:0]  h_pass, h_fail, h_fidx;

  aes_kat_checker #(.DEPTH(4), .CNT_W(16), .HALT_ON_ERR(1)) u_halt (
    .clk(clk), .reset(h_rst), .i_clear(h_clr),
    .i_exp_data(h_ed), .i_exp_valid(h_ev), .o_exp_ready(h_rdy),
    .i_data(h_d), .i_data_valid(h_dv),
    .o_pass_cnt(h_pass), .o_fail_cnt(h_fail), .o_error(h_err), .o_unexp(h_unexp),
    .o_fail_idx(h_fidx), .o_fail_data(h_fdata), .o_fail_exp(h_fexp), .o_idle(h_idle)
  );

  // narrow-counter instance for saturation and index wrap
  logic         s_rst, s_clr, s_ev, s_dv, s_rdy, s_err, s_unexp, s_idle;
  logic [127:0] s_ed, s_d, s_fdata, s_fexp;
  logic [7:0]   s_pass, s_fail, s_fidx;

  aes_kat_checker #(.DEPTH(2), .CNT_W(8), .HALT_ON_ERR(0)) u_sat (
    .clk(clk), .reset(s_rst), .i_clear(s_clr),
    .i_exp_data(s_ed), .i_exp_valid(s_ev), .o_exp_ready(s_rdy),
    .i_data(s_d), .i_data_valid(s_dv),
    .o_pass_cnt(s_pass), .o_fail_cnt(s_fail), .o_error(s_err), .o_unexp(s_unexp),
    .o_fail_idx(s_fidx), .o_fail_data(s_fdata), .o_fail_exp(s_fexp), .o_idle(s_idle)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model of the main instance: queue of expected blocks plus one pending result.
  logic [127:0] mq[$];
  bit           pv;
  logic [127:0] pd, pe;
  int           mpass, mfail, midx, mfidx;
  bit           merr, munexp, mcap;
  logic [127:0] mfdata, mfexp;

  task automatic model_clear();
    mq.delete();
    pv = 0; pd = '0; pe = '0;
    mpass = 0; mfail = 0; midx = 0; mfidx = 0;
    merr = 0; munexp = 0; mcap = 0;
    mfdata = '0; mfexp = '0;
  endtask

  task automatic model_edge(input bit clr, input bit ev, input logic [127:0] ed,
                            input bit dv, input logic [127:0] d);
    bit           nv;
    logic [127:0] nd, ne;
    bit           had_room;
    had_room = (mq.size() < 4);
    nv = 0; nd = '0; ne = '0;
    if (clr) begin
      model_clear();
      return;
    end
    if (pv) begin
      if (pd == pe) begin
        if (mpass < 65535) mpass++;
      end else begin
        if (mfail < 65535) mfail++;
        merr = 1;
        if (!mcap) begin
          mcap = 1; mfidx = midx; mfdata = pd; mfexp = pe;
        end
      end
      midx = (midx + 1) % 65536;
    end
    if (dv) begin
      if (mq.size() > 0) begin
        nv = 1; nd = d; ne = mq.pop_front();
      end else begin
        munexp = 1; merr = 1;
      end
    end
    if (ev && had_room) mq.push_back(ed);
    pv = nv; pd = nd; pe = ne;
  endtask

  task automatic step(input bit rst, input bit clr, input bit ev, input logic [127:0] ed,
                      input bit dv, input logic [127:0] d);
    m_rst = rst; m_clr = clr; m_ev = ev; m_ed = ed; m_dv = dv; m_d = d;
    @(posedge clk);
    model_edge(rst || clr, ev, ed, dv, d);
    #1;
    chk("pass", 128'(m_pass), 128'(mpass));
    chk("fail", 128'(m_fail), 128'(mfail));
    chk("error", 128'(m_err), 128'(merr));
    chk("unexp", 128'(m_unexp), 128'(munexp));
    chk("ready", 128'(m_rdy), 128'(mq.size() < 4));
    chk("idle", 128'(m_idle), 128'(mq.size() == 0 && !pv));
    chk("fidx", 128'(m_fidx), 128'(mfidx));
    chk("fdata", m_fdata, mfdata);
    chk("fexp", m_fexp, mfexp);
    m_rst = 0; m_clr = 0; m_ev = 0; m_dv = 0;
  endtask

  initial begin
    logic [127:0] v, w, dd;
    logic [127:0] blk [4];
    bit           ev, dv, clr, rst;

    m_rst = 1; m_clr = 0; m_ev = 0; m_ed = '0; m_dv = 0; m_d = '0;
    h_rst = 1; h_clr = 0; h_ev = 0; h_ed = '0; h_dv = 0; h_d = '0;
    s_rst = 1; s_clr = 0; s_ev = 0; s_ed = '0; s_dv = 0; s_d = '0;
    model_clear();

    // ---- main instance: reset state and known-answer cases ----
    step(1, 0, 0, '0, 0, '0);
    step(1, 0, 0, '0, 0, '0);
    chk("rst_pass", 128'(m_pass), 0);
    chk("rst_ready", 128'(m_rdy), 1);
    chk("rst_idle", 128'(m_idle), 1);

    step(0, 0, 1, KAT, 0, '0);
    step(0, 0, 0, '0, 1, KAT);
    step(0, 0, 0, '0, 0, '0);
    chk("kat_pass", 128'(m_pass), 1);
    chk("kat_fail", 128'(m_fail), 0);
    chk("kat_err", 128'(m_err), 0);
    chk("kat_idle", 128'(m_idle), 1);

    step(0, 1, 0, '0, 0, '0);
    step(0, 0, 1, KAT, 0, '0);
    step(0, 0, 0, '0, 1, KAT ^ 128'h1);
    step(0, 0, 0, '0, 0, '0);
    chk("mis_fail", 128'(m_fail), 1);
    chk("mis_err", 128'(m_err), 1);
    chk("mis_idx", 128'(m_fidx), 0);
    chk("mis_data", m_fdata, 128'h69c4e0d86a7b0430d8cdb78070b4c55b);
    chk("mis_exp", m_fexp, KAT);

    step(0, 1, 0, '0, 0, '0);
    for (int i = 0; i < 4; i++) begin
      blk[i] = {$urandom, $urandom, $urandom, $urandom};
      step(0, 0, 1, blk[i], 0, '0);
    end
    chk("full_ready", 128'(m_rdy), 0);
    step(0, 0, 1, 128'hdead, 0, '0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 1, blk[i]);
    step(0, 0, 0, '0, 0, '0);
    chk("full_pass", 128'(m_pass), 4);
    chk("full_ready2", 128'(m_rdy), 1);

    step(0, 1, 0, '0, 0, '0);
    step(0, 0, 0, '0, 1, KAT);
    step(0, 0, 0, '0, 0, '0);
    chk("unexp_flag", 128'(m_unexp), 1);
    chk("unexp_err", 128'(m_err), 1);
    chk("unexp_cnt", 128'({m_pass, m_fail}), 0);

    // reset on the comparison edge drops the pending result
    step(0, 1, 0, '0, 0, '0);
    step(0, 0, 1, KAT, 0, '0);
    step(0, 0, 0, '0, 1, KAT);
    step(1, 0, 0, '0, 0, '0);
    step(0, 0, 0, '0, 0, '0);
    chk("rstmid_pass", 128'(m_pass), 0);

    // ---- main instance: randomized traffic ----
    for (int n = 0; n < 500; n++) begin
      ev  = ($urandom_range(0, 1) == 1);
      dv  = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 59) == 0);
      rst = ($urandom_range(0, 89) == 0);
      v   = {$urandom, $urandom, $urandom, $urandom};
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) dd = mq[0];
      else dd = {$urandom, $urandom, $urandom, $urandom};
      step(rst, clr, ev, v, dv, dd);
    end

    // ---- halt-on-error instance ----
    v = {$urandom, $urandom, $urandom, $urandom};
    w = {$urandom, $urandom, $urandom, $urandom};
    tick(); h_rst = 0;
    h_ev = 1; h_ed = v; tick();
    h_ed = w; tick();
    h_ev = 0; h_dv = 1; h_d = ~v; tick();
    h_d = w; tick();
    h_dv = 0; tick();
    chk("halt_fail", 128'(h_fail), 1);
    chk("halt_err", 128'(h_err), 1);
    chk("halt_ready", 128'(h_rdy), 0);
    chk("halt_idle", 128'(h_idle), 0);
    chk("halt_pass", 128'(h_pass), 0);
    chk("halt_fdata", h_fdata, ~v);
    h_ev = 1; h_ed = KAT; h_dv = 1; h_d = KAT; tick();
    h_ev = 0; h_dv = 0; tick(); tick();
    chk("halt_pass2", 128'(h_pass), 0);
    chk("halt_unexp", 128'(h_unexp), 0);
    h_clr = 1; tick(); h_clr = 0;
    chk("hclr_cnts", 128'({h_pass, h_fail, h_fidx}), 0);
    chk("hclr_flags", 128'({h_err, h_unexp}), 0);
    chk("hclr_cap", h_fdata | h_fexp, 0);
    chk("hclr_ready", 128'(h_rdy), 1);
    chk("hclr_idle", 128'(h_idle), 1);

    // ---- narrow-counter instance: saturation then index wrap ----
    s_rst = 0;
    v = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 256; i++) begin
      s_ev = 1; s_ed = v; s_dv = (i > 0); s_d = v; tick();
    end
    s_ev = 0; s_dv = 1; tick();
    s_dv = 0; tick(); tick();
    chk("sat_pass", 128'(s_pass), 255);
    chk("sat_fail", 128'(s_fail), 0);
    chk("sat_idle", 128'(s_idle), 1);
    s_ev = 1; s_ed = v; tick();
    s_ev = 0; s_dv = 1; s_d = ~v; tick();
    s_dv = 0; tick(); tick();
    chk("wrap_fail", 128'(s_fail), 1);
    chk("wrap_idx", 128'(s_fidx), 0);
    chk("wrap_data", s_fdata, ~v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
